// File: rtl/sigma_delta_adc_if.sv
// rtl/sigma_delta_adc_if.sv - PCM sample output bundle of the sigma-delta ADC front end
interface sigma_delta_adc_if #(
    parameter int W = 8
);
    logic [W-1:0] sample;
    logic         sample_valid;
    logic         overload;
    logic         ear_bit;

    // The ADC drives the bundle; the capture logic only observes it
    modport master (
        output sample,
        output sample_valid,
        output overload,
        output ear_bit
    );

    modport slave (
        input sample,
        input sample_valid,
        input overload,
        input ear_bit
    );
endinterface

// File: rtl/sigma_delta_adc.sv
// rtl/sigma_delta_adc.sv - 1-bit sigma-delta ADC front end with box-car decimator and tape-level hysteresis
// Optional feature macro: SDADC_AUTO_THRESH_EN (hysteresis band centred on a tracked signal average)
module sigma_delta_adc #(
    parameter int DECIM_LOG2 = 8,
    parameter int HYST_HI    = 160,
    parameter int HYST_LO    = 96,
    parameter int HYST_DELTA = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmp_in,
    output logic              fb_out,
    sigma_delta_adc_if.master pcm
);

    localparam int W = DECIM_LOG2;
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] SAT     = '1;
    localparam logic [W:0]   FULL    = {1'b1, {W{1'b0}}};

    // Comparator synchroniser and feedback flop
    logic s1_q, s2_q, fb_q;

    // Decimator state
    logic [W-1:0] cnt_q;
    logic [W:0]   acc_q, acc_d;
    logic [W:0]   total;
    logic [W-1:0] value;
    logic         win_end;

    // Output registers
    logic [W-1:0] sample_q, sample_d;
    logic         valid_q;
    logic         ovl_q, ovl_d;
    logic         ear_q, ear_d;

    // Active hysteresis thresholds for the current sample edge
    logic [W-1:0] thr_hi, thr_lo;

    // Window bookkeeping: total includes the current bit so the last clock of a window is counted
    always_comb begin
        win_end  = (cnt_q == CNT_MAX);
        total    = acc_q + (W+1)'(s2_q);
        value    = total[W] ? SAT : total[W-1:0];
        acc_d    = win_end ? '0 : total;
        sample_d = win_end ? value : sample_q;
        ovl_d    = win_end ? ((total == '0) || (total == FULL)) : ovl_q;
    end

`ifdef SDADC_AUTO_THRESH_EN
    localparam logic [W+3:0] AVG_RST = (W+4)'(1) << (W+3);
    localparam logic [W+1:0] DELTA_W = (W+2)'(HYST_DELTA);

    logic [W+3:0] avg_q, avg_d;
    logic [W-1:0] mean;
    logic [W+1:0] hi_sum;

    // Band centred on the pre-update average, clamped into the sample range
    always_comb begin
        mean   = avg_q[W+3:4];
        hi_sum = {2'b00, mean} + DELTA_W;
        thr_hi = (hi_sum > {2'b00, SAT}) ? SAT : hi_sum[W-1:0];
        thr_lo = ({2'b00, mean} < DELTA_W) ? '0 : (mean - DELTA_W[W-1:0]);
        avg_d  = avg_q;
        if (win_end) begin
            avg_d = (W+4)'({1'b0, avg_q} + {5'b00000, value} - {5'b00000, mean});
        end
    end

    // Leaky average of samples, 4 fractional bits
    always_ff @(posedge clk) begin
        if (reset) begin
            avg_q <= AVG_RST;
        end else begin
            avg_q <= avg_d;
        end
    end
`else
    // Fixed band
    always_comb begin
        thr_hi = W'(HYST_HI);
        thr_lo = W'(HYST_LO);
    end
`endif

    // Schmitt decision on the saturated window value; between thresholds the level holds
    always_comb begin
        ear_d = ear_q;
        if (win_end) begin
            if (value >= thr_hi) begin
                ear_d = 1'b1;
            end else if (value <= thr_lo) begin
                ear_d = 1'b0;
            end
        end
    end

    // All state; a mid-window reset simply drops the partial count
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            fb_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovl_q    <= 1'b0;
            ear_q    <= 1'b0;
        end else begin
            s1_q     <= cmp_in;
            s2_q     <= s1_q;
            fb_q     <= s2_q;
            cnt_q    <= cnt_q + W'(1);
            acc_q    <= acc_d;
            sample_q <= sample_d;
            valid_q  <= win_end;
            ovl_q    <= ovl_d;
            ear_q    <= ear_d;
        end
    end

    assign fb_out           = fb_q;
    assign pcm.sample       = sample_q;
    assign pcm.sample_valid = valid_q;
    assign pcm.overload     = ovl_q;
    assign pcm.ear_bit      = ear_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// tb/tb_sigma_delta_adc.sv - scoreboard bench for sigma_delta_adc with directed duty patterns
module tb_sigma_delta_adc;

    localparam int W       = 8;
    localparam int N       = 256;
    localparam int HYST_HI = 160;
    localparam int HYST_LO = 96;

    localparam int M0  = 0;
    localparam int M1  = 1;
    localparam int M50 = 2;
    localparam int M75 = 3;
    localparam int M25 = 4;

    initial assert (HYST_HI > HYST_LO) else $fatal(1, "hysteresis thresholds inverted");

    typedef struct {
        int sample;
        int ovl;
        int ear;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmp_in = 1'b0;
    logic fb_out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   fb_chk_en = 1'b0;
    int   modes[$];
    exp_t exp_q[$];

    sigma_delta_adc_if #(.W(W)) pcm_if ();

    sigma_delta_adc dut (
        .clk    (clk),
        .reset  (reset),
        .cmp_in (cmp_in),
        .fb_out (fb_out),
        .pcm    (pcm_if)
    );

    always #5 clk = ~clk;

    // Cycle index: 0 is the first cycle with reset low
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Desired synchronised comparator value for cycle t
    function automatic logic pat(int t);
        int w;
        int p;
        int m;
        w = t / N;
        p = t % N;
        m = (w < modes.size()) ? modes[w] : M0;
        case (m)
            M1:      return 1'b1;
            M50:     return (p % 2) == 1;
            M75:     return (p % 4) != 0;
            M25:     return (p % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(int s, int o, int e, int c);
        exp_t x;
        x.sample = s;
        x.ovl    = o;
        x.ear    = e;
        x.cyc    = c;
        exp_q.push_back(x);
    endtask

    // Stimulus: the synchroniser adds two cycles, so drive two cycles ahead
    initial forever begin
        @(negedge clk);
        cmp_in = pat(cyc + 2);
    end

    // fb_out mirrors cmp_in three clocks late
    initial forever begin
        @(negedge clk);
        if (fb_chk_en) check("fb_out", int'(fb_out), (cyc >= 3) ? int'(pat(cyc - 1)) : 0);
    end

    // Monitor: pop one expectation per strobe
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (pcm_if.sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sample", int'(pcm_if.sample), e.sample);
                check("overload", int'(pcm_if.overload), e.ovl);
                check("ear_bit", int'(pcm_if.ear_bit), e.ear);
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic begin_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_reset();
        @(negedge clk);
        check("rst_sample", int'(pcm_if.sample), 0);
        check("rst_valid", int'(pcm_if.sample_valid), 0);
        check("rst_overload", int'(pcm_if.overload), 0);
        check("rst_ear_bit", int'(pcm_if.ear_bit), 0);
        check("rst_fb_out", int'(fb_out), 0);
        fb_chk_en = 1'b1;
        reset = 1'b0;
    endtask

    task automatic run_until(int c);
        int guard = 0;
        while (cyc < c && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_cycle", int'(cyc >= c), 1);
    endtask

    initial begin
`ifndef SDADC_AUTO_THRESH_EN
        // Held high, then toggling: ear_bit must hold at 1 through midscale
        begin_reset();
        modes = '{M1, M1, M50, M50};
        push(254, 0, 1, 256);
        push(255, 1, 1, 512);
        push(128, 0, 1, 768);
        push(128, 0, 1, 1024);
        end_reset();
        run_until(1030);
        check("pending_t1", exp_q.size(), 0);

        // Held low
        begin_reset();
        modes = '{M0, M0};
        push(0, 1, 0, 256);
        push(0, 1, 0, 512);
        end_reset();
        run_until(520);
        check("pending_t2", exp_q.size(), 0);

        // Duty steps 50/75/50/25 after a warm-up window
        begin_reset();
        modes = '{M0, M50, M75, M50, M25};
        push(0, 1, 0, 256);
        push(128, 0, 0, 512);
        push(192, 0, 1, 768);
        push(128, 0, 1, 1024);
        push(64, 0, 0, 1280);
        end_reset();
        run_until(1290);
        check("pending_t3", exp_q.size(), 0);
`else
        // Tracked threshold: long 75% stretch, then 25%
        begin_reset();
        modes.delete();
        for (int i = 0; i < 64; i++) modes.push_back(M75);
        modes.push_back(M25);
        push(191, 0, 1, 256);
        for (int k = 1; k < 64; k++) push(192, 0, 1, N * (k + 1));
        push(64, 0, 0, N * 65);
        end_reset();
        run_until(N * 65 + 4);
        check("pending_auto", exp_q.size(), 0);
`endif

        // One-clock reset at cnt=100 of the second window
        begin_reset();
        modes = '{M1, M1, M1};
        push(254, 0, 1, 256);
        end_reset();
        run_until(356);
        reset = 1'b1;
        @(negedge clk);
        check("mid_sample", int'(pcm_if.sample), 0);
        check("mid_valid", int'(pcm_if.sample_valid), 0);
        check("mid_overload", int'(pcm_if.overload), 0);
        check("mid_ear_bit", int'(pcm_if.ear_bit), 0);
        check("mid_fb_out", int'(fb_out), 0);
        reset = 1'b0;
        push(254, 0, 1, 256);
        run_until(262);
        check("pending_t4", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
